// File: rtl/add_arbiter_pkg.sv
// rtl/add_arbiter_pkg.sv - shared FSM state type and default width for the add arbiter
package add_arbiter_pkg;

  localparam int ADD_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/add_arbiter_rca5.sv
// rtl/add_arbiter_rca5.sv - WIDTH-bit ripple-carry adder shared by both requesters
module rca5
  import add_arbiter_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter granting two requesters one shared adder
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             sel;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] sum_w;
  logic             cout_w;

  // Pointer only breaks ties; a lone requester wins regardless.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ptr;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  // Gated by rst_n so both readies read 0 while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~sel;
  assign req1_ready = rst_n & (state == IDLE) & req1_valid & sel;
  assign accept     = req0_ready | req1_ready;

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= sel ? req1_a : req0_a;
        op_b   <= sel ? req1_b : req0_b;
        op_cin <= sel ? req1_cin : req0_cin;
        rsp_id <= sel;
        ptr    <= ~sel;
      end
      if (state == EXEC) begin
        rsp_sum  <= sum_w;
        rsp_cout <= cout_w;
      end
    end
  end

  rca5 #(
    .WIDTH(WIDTH)
  ) u_rca5 (
    .a   (op_a),
    .b   (op_b),
    .cin (op_cin),
    .sum (sum_w),
    .cout(cout_w)
  );

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - directed and randomized self-checking bench for add_arbiter
module tb_add_arbiter;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  add_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_cin  (req0_cin),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_cin  (req1_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_single(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    check("single_ready0", req0_ready, !id);
    check("single_ready1", req1_ready, id);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("single_exec_busy", busy, 1);
    check("single_exec_rsp_valid", rsp_valid, 0);
    next_cycle();
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_sum", rsp_sum, exp_sum);
    check("single_rsp_cout", rsp_cout, exp_cout);
    check("single_rsp_id", rsp_id, id);
    next_cycle();
    check("single_done_valid", rsp_valid, 0);
    check("single_done_busy", busy, 0);
  endtask

  initial begin
    int            grants, resps, last_g;
    int            accepted, returned, cyc;
    logic          m_ptr, inflight, exp_r0, exp_r1, gid;
    logic [5:0]    tot;
    logic [6:0]    exp_q[$];
    logic [6:0]    ent;

    // Reset state, with valids asserted to show readies stay low.
    clear_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;

    run_single(1'b0, 5'd13, 5'd9, 1'b1, 5'd23, 1'b0);
    run_single(1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1);
    run_single(1'b1, 5'd16, 5'd16, 1'b0, 5'd0, 1'b1);
    run_single(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // Contention: both valid continuously.
    reset_dut();
    req0_valid = 1'b1; req0_a = 5'd1;  req0_b = 5'd2;  req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 5'd10; req1_b = 5'd20; req1_cin = 1'b1;
    rsp_ready = 1'b1;
    grants = 0; resps = 0; last_g = 0;
    for (int c = 0; c < 40 && resps < 6; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("cont_both_ready", req0_ready & req1_ready, 0);
        check("cont_grant_id", req1_ready, grants % 2);
        if (grants > 0) check("cont_interval", c - last_g, 3);
        last_g = c;
        grants++;
      end
      if (rsp_valid) begin
        check("cont_rsp_id", rsp_id, resps % 2);
        check("cont_rsp_sum", rsp_sum, (resps % 2) ? 31 : 3);
        resps++;
      end
      next_cycle();
    end
    check("cont_resp_count", resps, 6);
    clear_inputs();
    next_cycle();

    // Backpressure in RESP; pointer is 0 here.
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd8; req0_cin = 1'b0;
    #1;
    check("bp_ready0", req0_ready, 1);
    next_cycle();
    req1_valid = 1'b1;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_sum", rsp_sum, 15);
      check("bp_rsp_cout", rsp_cout, 0);
      check("bp_rsp_id", rsp_id, 0);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
      check("bp_busy", busy, 1);
      next_cycle();
    end
    clear_inputs();
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", rsp_valid, 1);
    next_cycle();
    check("bp_done_valid", rsp_valid, 0);
    check("bp_done_busy", busy, 0);

    // Reset during EXEC; pointer is 1 here so req1 wins first.
    req0_valid = 1'b1; req0_a = 5'd3;  req0_b = 5'd4; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 5'd20; req1_b = 5'd5; req1_cin = 1'b1;
    #1;
    check("rexec_pre_ready1", req1_ready, 1);
    check("rexec_pre_ready0", req0_ready, 0);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("rexec_busy", busy, 0);
    check("rexec_rsp_valid", rsp_valid, 0);
    check("rexec_ready0", req0_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rexec_post_ready0", req0_ready, 1);
    check("rexec_post_ready1", req1_ready, 0);
    next_cycle();
    check("rexec_no_stale_rsp", rsp_valid, 0);
    next_cycle();
    check("rexec_new_rsp_valid", rsp_valid, 1);
    check("rexec_new_rsp_id", rsp_id, 0);
    check("rexec_new_rsp_sum", rsp_sum, 7);
    clear_inputs();
    rsp_ready = 1'b1;
    next_cycle();

    // Random traffic against a scoreboard.
    reset_dut();
    m_ptr = 1'b0; inflight = 1'b0;
    accepted = 0; returned = 0; cyc = 0;
    while (returned < 1000 && cyc < 20000) begin
      if (accepted < 1000) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req1_valid = ($urandom_range(0, 99) < 60);
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      rsp_ready = 1'($urandom);
      #1;
      gid    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      exp_r0 = !inflight && req0_valid && !gid;
      exp_r1 = !inflight && req1_valid && gid;
      check("rnd_ready0", req0_ready, exp_r0);
      check("rnd_ready1", req1_ready, exp_r1);
      if (exp_r0 || exp_r1) begin
        if (gid) tot = {1'b0, req1_a} + {1'b0, req1_b} + {5'd0, req1_cin};
        else     tot = {1'b0, req0_a} + {1'b0, req0_b} + {5'd0, req0_cin};
        exp_q.push_back({gid, tot});
        m_ptr = ~gid;
        inflight = 1'b1;
        accepted++;
      end
      if (rsp_valid && rsp_ready) begin
        check("rnd_rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          check("rnd_rsp_id", rsp_id, ent[6]);
          check("rnd_rsp_result", {rsp_cout, rsp_sum}, ent[5:0]);
        end
        returned++;
        inflight = 1'b0;
      end
      next_cycle();
      cyc++;
    end
    check("rnd_accepted", accepted, 1000);
    check("rnd_returned", returned, 1000);
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/sum width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n offers an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester n's operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands, bit 0 = LSB.
REQ-007 SHALL have ports req0_cin / req1_cin  input  1  carry-in.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_id  output  1  requester the result belongs to.
REQ-011 SHALL have ports rsp_sum  output  WIDTH  and rsp_cout  output  1  result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL share one WIDTH-bit adder between the two requesters; at most one operation in flight.
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqN_valid, grant one, latch its a/b/cin and id, go EXEC; else stay.
REQ-016 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; transfer = valid & ready.
REQ-017 Arbitration SHALL be round-robin: priority pointer starts at 0; after each grant it points to the other requester; a lone valid requester is granted regardless of pointer.
REQ-018 EXEC: lasts exactly one cycle; register adder outputs into rsp_sum/rsp_cout; go RESP.
REQ-019 RESP: rsp_valid=1, rsp_sum/rsp_cout/rsp_id held stable until rsp_valid & rsp_ready; then IDLE.
REQ-020 Latency: operation accepted at edge t SHALL give rsp_valid high after edge t+2; min issue interval 3 cycles.
REQ-021 Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, WIDTH+1-bit exact, no saturation.
REQ-022 Requester inputs SHALL be ignored outside IDLE; a requester may change or drop valid before ready without effect.
REQ-023 rsp_ready outside RESP SHALL have no effect.
REQ-024 Both valids in the same cycle: only pointer-selected requester gets ready; the other stays pending.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, pointer 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, busy 0, both ready 0.
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation; no response produced for it.
REQ-027 First grant after reset deassertion SHALL follow REQ-017 with pointer 0.

Structure
REQ-028 Shared package SHALL hold the FSM state enum and WIDTH default constant.
REQ-029 Adder SHALL be one instantiated sub-module rca5 (WIDTH-bit ripple-carry, a, b, cin -> sum, cout); arbiter holds no other arithmetic.
REQ-030 Latched operands, id, result and pointer SHALL be flops; no latches, no combinational loop through rsp_ready.

Verification
REQ-031 Single op: req0 a=5'd13 b=5'd9 cin=1 -> req0_ready pulse, rsp_valid at t+2, rsp_sum=5'd23 rsp_cout=0 rsp_id=0.
REQ-032 Overflow: req1 a=5'd31 b=5'd31 cin=1 -> rsp_sum=5'd31 rsp_cout=1 rsp_id=1; also a=5'd16 b=5'd16 cin=0 -> sum 0, cout 1.
REQ-033 Contention: both valid continuously, 6 ops -> rsp_id sequence 0,1,0,1,0,1, each issue 3 cycles apart.
REQ-034 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp outputs stable, both ready 0, busy 1; accept on rsp_ready=1.
REQ-035 Reset in EXEC: rst_n low for 1 cycle -> rsp_valid never asserts for that op, next grant goes to req0 if both valid.
REQ-036 Random: 1000 ops random valids/operands/rsp_ready vs reference model -> every accepted op returns exactly once, correct id and sum.
